// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
package mips_pkg;

  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned WR_CNT_W   = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Active-low strobe levels on the core data port
  localparam logic CEN_ON    = 1'b0;
  localparam logic WEN_WRITE = 1'b0;
  localparam logic WEN_READ  = 1'b1;
  localparam logic OEN_ON    = 1'b0;

endpackage

// File: rtl/mem_array.sv
// Word array with one asynchronous read port and one synchronous write port.
module mem_array #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port; contents are not reset (the clear sequencer zeroes them)
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle MIPS core: combinational reads,
// clocked writes, a preload handshake port and a post-reset clear sequencer.
import mips_pkg::*;

module data_mem_responder #(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CEN,
  input  logic                WEN,
  input  logic                OEN,
  input  logic [ADDR_W-1:0]   A,
  input  logic [DATA_W-1:0]   D,
  output logic [DATA_W-1:0]   Q,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                init_done,
  output logic [WR_CNT_W-1:0] wr_count
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WR_CNT_W-1:0] CNT_MAX   = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [WR_CNT_W-1:0] wr_count_q, wr_count_d;

  logic                core_wr;
  logic                core_rd;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  assign core_wr = (CEN == CEN_ON) && (WEN == WEN_WRITE);
  assign core_rd = (state_q == READY) && (CEN == CEN_ON) &&
                   (WEN == WEN_READ) && (OEN == OEN_ON);

  // State, clear pointer and write counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next state and write-port mux: clear beats core, core beats preload
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
    mem_waddr  = A;
    mem_wdata  = D;
    ld_ready   = 1'b0;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        ld_ready = !core_wr;
        if (core_wr) begin
          mem_we = 1'b1;
          if (wr_count_q != CNT_MAX) begin
            wr_count_d = wr_count_q + WR_CNT_W'(1);
          end
        end else if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wdata = ld_data;
        end
      end
      default: state_d = CLEAR;
    endcase
    // Any write in flight on a reset edge is dropped
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (A),
    .rdata (mem_rdata)
  );

  assign Q         = core_rd ? mem_rdata : '0;
  assign init_done = (state_q == READY);
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        ld_valid;
  logic        ld_ready;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;
  logic        init_done;
  logic [15:0] wr_count;

  int n_total = 0;
  int n_pass  = 0;

  data_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .CEN       (CEN),
    .WEN       (WEN),
    .OEN       (OEN),
    .A         (A),
    .D         (D),
    .Q         (Q),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .init_done (init_done),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; ld_valid = 1'b0;
  endtask

  task automatic rd(input logic [6:0] addr);
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = addr;
  endtask

  task automatic wr(input logic [6:0] addr, input logic [31:0] data);
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = addr; D = data;
  endtask

  initial begin
    rst = 1'b1; A = '0; D = '0; ld_addr = '0; ld_data = '0;
    idle();
    @(negedge clk); @(negedge clk);
    // Reset values, with a read attempt that must be ignored
    rd(7'h00);
    #1;
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_wr_count",  32'(wr_count),  32'd0);
    check("rst_ld_ready",  32'(ld_ready),  32'd0);
    check("rst_q",         Q,              32'd0);

    // Clear sequence: init_done rises on the 128th edge after release
    @(negedge clk);
    rst = 1'b0;
    idle();
    ld_valid = 1'b1; ld_addr = 7'h10; ld_data = 32'h5;
    repeat (127) @(negedge clk);
    #1;
    check("clr_127_init_done", 32'(init_done), 32'd0);
    check("clr_ld_ready",      32'(ld_ready),  32'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    check("clr_128_init_done", 32'(init_done), 32'd1);
    rd(7'h55);
    #1;
    check("ready_q_55", Q, 32'd0);

    // Preload mem[3] then read it back
    @(negedge clk);
    idle();
    ld_valid = 1'b1; ld_addr = 7'd3; ld_data = 32'hDEADBEEF;
    #1;
    check("pre_ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
    rd(7'd3);
    #1;
    check("pre_q3",       Q,              32'hDEADBEEF);
    check("pre_wr_count", 32'(wr_count),  32'd0);

    // Core write A=9 while read strobes are low: old value, then new
    @(negedge clk);
    wr(7'd9, 32'h0000CAFE);
    OEN = 1'b0;
    #1;
    check("w9_q_old",     Q,             32'd0);
    check("w9_cnt_before", 32'(wr_count), 32'd0);
    @(negedge clk);
    rd(7'd9);
    #1;
    check("w9_q_new",     Q,             32'h0000CAFE);
    check("w9_cnt_after", 32'(wr_count), 32'd1);
    OEN = 1'b1;
    #1;
    check("w9_oen_off", Q, 32'd0);
    OEN = 1'b0; CEN = 1'b1;
    #1;
    check("w9_cen_off", Q, 32'd0);

    // Core write and preload to the same word: core first, preload next cycle
    @(negedge clk);
    wr(7'd5, 32'h1);
    ld_valid = 1'b1; ld_addr = 7'd5; ld_data = 32'h2;
    #1;
    check("cont_ld_blocked", 32'(ld_ready), 32'd0);
    @(negedge clk);
    rd(7'd5);
    #1;
    check("cont_ld_accept", 32'(ld_ready), 32'd1);
    check("cont_q_core",    Q,             32'h1);
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    check("cont_q_pre", Q,             32'h2);
    check("cont_cnt",   32'(wr_count), 32'd2);

    // Blocked preload, then reset with writes in flight, then reset mid-clear
    @(negedge clk);
    wr(7'd10, 32'h77);
    ld_valid = 1'b1; ld_addr = 7'd11; ld_data = 32'h99;
    #1;
    check("rr_ld_blocked", 32'(ld_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rr_init_done_rst", 32'(init_done), 32'd0);
    check("rr_cnt_rst",       32'(wr_count),  32'd0);
    rst = 1'b0;
    idle();
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (127) @(negedge clk);
    #1;
    check("rr_127_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    #1;
    check("rr_128_init_done", 32'(init_done), 32'd1);
    check("rr_wr_count",      32'(wr_count),  32'd0);
    for (int i = 0; i < 128; i++) begin
      rd(7'(i));
      #1;
      check($sformatf("rr_zero_%0d", i), Q, 32'd0);
    end

    // Saturating write counter
    @(negedge clk);
    wr(7'd20, 32'hA5A50000);
    repeat (65534) @(negedge clk);
    #1;
    check("sat_fffe", 32'(wr_count), 32'h0000FFFE);
    @(negedge clk);
    #1;
    check("sat_ffff", 32'(wr_count), 32'h0000FFFF);
    repeat (4465) @(negedge clk);
    #1;
    check("sat_hold", 32'(wr_count), 32'h0000FFFF);
    rd(7'd20);
    #1;
    check("sat_q20", Q, 32'hA5A50000);
    OEN = 1'b1;
    #1;
    check("sat_oen_off", Q, 32'd0);
    OEN = 1'b0; CEN = 1'b1;
    #1;
    check("sat_cen_off", Q, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
